// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons with a shared threshold, per-channel
// refractory counters and a saturating aggregate spike counter.
module lif_neuron_array #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [N*W-1:0]     current_i,
  input  logic [W-1:0]       threshold_i,
  input  logic               clr_count_i,
  output logic [N*W-1:0]     state_o,
  output logic [N-1:0]       spike_o,
  output logic [CNT_W-1:0]   spike_count_o
);

  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  logic [W-1:0]     state_q [N];
  logic [W-1:0]     state_d [N];
  logic [RW-1:0]    r_q     [N];
  logic [RW-1:0]    r_d     [N];
  logic [N-1:0]     spike_q, spike_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    cnt_sum;

  for (genvar g = 0; g < N; g++) begin : gen_ch
    logic [W:0]   sum;
    logic [W-1:0] sum_sat;
    logic         fire;

    always_comb begin
      sum     = {1'b0, state_q[g] >> LEAK_SHIFT} + {1'b0, current_i[g*W +: W]};
      sum_sat = sum[W] ? {W{1'b1}} : sum[W-1:0];
      fire    = (threshold_i != '0) && (sum_sat >= threshold_i);

      state_d[g] = state_q[g];
      r_d[g]     = r_q[g];
      spike_d[g] = 1'b0;
      if (en_i) begin
        if (r_q[g] != '0) begin
          // Refractory: input is ignored and the membrane is held at rest.
          state_d[g] = '0;
          r_d[g]     = r_q[g] - 1'b1;
        end else if (fire) begin
          spike_d[g] = 1'b1;
          state_d[g] = '0;
          r_d[g]     = RW'(REFRAC);
        end else begin
          state_d[g] = sum_sat;
        end
      end
    end

    assign state_o[g*W +: W] = state_q[g];
  end

  // Counter sees the spikes being registered this edge, so it agrees with spike_o.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(spike_d[i]);
    end
    cnt_sum = SW'(cnt_q) + SW'(pop);
    if (clr_count_i) begin
      cnt_d = '0;
    end else if (cnt_sum > SW'({CNT_W{1'b1}})) begin
      cnt_d = {CNT_W{1'b1}};
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= '0;
        r_q[i]     <= '0;
      end
      spike_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        r_q[i]     <= r_d[i];
      end
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike_o       = spike_q;
  assign spike_count_o = cnt_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Table-driven bench for lif_neuron_array; a CNT_W=4 copy shares the stimulus to
// exercise counter saturation.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic [31:0] cur;
  logic [7:0]  thr;
  logic [31:0] st, st4;
  logic [3:0]  sp, sp4;
  logic [7:0]  cnt;
  logic [3:0]  cnt4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lif_neuron_array #(.N(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .current_i    (cur),
    .threshold_i  (thr),
    .clr_count_i  (clr),
    .state_o      (st),
    .spike_o      (sp),
    .spike_count_o(cnt)
  );

  lif_neuron_array #(.N(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .CNT_W(4)) dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .current_i    (cur),
    .threshold_i  (thr),
    .clr_count_i  (clr),
    .state_o      (st4),
    .spike_o      (sp4),
    .spike_count_o(cnt4)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [31:0] cur;
    logic [7:0]  thr;
    logic [31:0] st;
    logic [3:0]  sp;
    logic [7:0]  cnt;
    logic [3:0]  cnt4;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input logic [31:0] cu,
                     input logic [7:0] th, input logic [31:0] s, input logic [3:0] p,
                     input logic [7:0] cn, input logic [3:0] c4);
    vec_t v;
    v.rst_n = r; v.en = e; v.clr = c; v.cur = cu; v.thr = th;
    v.st = s; v.sp = p; v.cnt = cn; v.cnt4 = c4;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [31:0] cu,
                      input logic [7:0] th);
    rst_n = r; en = e; clr = c; cur = cu; thr = th;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int exp_c4;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; cur = '0; thr = 8'd200;

    // Periodic firing, ch0 current 120 (period 5 steps)
    add(0, 1, 1, 32'h78, 200, 32'h00, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'h78, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'hB4, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'h00, 4'h1, 1, 1);
    add(1, 1, 0, 32'h78, 200, 32'h00, 4'h0, 1, 1);
    add(1, 1, 0, 32'h78, 200, 32'h00, 4'h0, 1, 1);
    add(1, 1, 0, 32'h78, 200, 32'h78, 4'h0, 1, 1);
    add(1, 1, 0, 32'h78, 200, 32'hB4, 4'h0, 1, 1);
    add(1, 1, 0, 32'h78, 200, 32'h00, 4'h1, 2, 2);
    // Reset mid-refractory must leave no residual refractory count
    add(1, 1, 0, 32'h78, 200, 32'h00, 4'h0, 2, 2);
    add(0, 1, 0, 32'h78, 200, 32'h00, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'h78, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'hB4, 4'h0, 0, 0);
    // Sub-threshold fixed point, ch0 current 100
    add(0, 0, 0, 32'h64, 200, 32'h00, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'h64, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'h96, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hAF, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hBB, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hC1, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hC4, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hC6, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hC7, 4'h0, 0, 0);
    add(1, 1, 0, 32'h64, 200, 32'hC7, 4'h0, 0, 0);
    // Saturation with firing disabled, ch1 current 255
    add(0, 0, 0, 32'hFF00, 0, 32'h0000, 4'h0, 0, 0);
    add(1, 1, 0, 32'hFF00, 0, 32'hFF00, 4'h0, 0, 0);
    add(1, 1, 0, 32'hFF00, 0, 32'hFF00, 4'h0, 0, 0);
    add(1, 1, 0, 32'hFF00, 0, 32'hFF00, 4'h0, 0, 0);
    // Enable gating holds state; the pulse is not stretched
    add(0, 0, 0, 32'h78, 200, 32'h00, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'h78, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'hB4, 4'h0, 0, 0);
    add(1, 0, 0, 32'h78, 200, 32'hB4, 4'h0, 0, 0);
    add(1, 0, 0, 32'h78, 200, 32'hB4, 4'h0, 0, 0);
    add(1, 0, 0, 32'h78, 200, 32'hB4, 4'h0, 0, 0);
    add(1, 1, 0, 32'h78, 200, 32'h00, 4'h1, 1, 1);
    add(1, 0, 0, 32'h78, 200, 32'h00, 4'h0, 1, 1);
    // Threshold change applies to the very next step
    add(0, 0, 0, 32'h96, 200, 32'h00, 4'h0, 0, 0);
    add(1, 1, 0, 32'h96, 200, 32'h96, 4'h0, 0, 0);
    add(1, 1, 0, 32'h96, 250, 32'hE1, 4'h0, 0, 0);
    add(1, 1, 0, 32'h96, 250, 32'h00, 4'h1, 1, 1);
    // Simultaneous spikes; clear wins over spikes in the same cycle
    add(0, 0, 0, 32'hFFFFFFFF, 200, 32'h00, 4'h0, 0, 0);
    add(1, 1, 0, 32'hFFFFFFFF, 200, 32'h00, 4'hF, 4, 4);
    add(1, 1, 0, 32'hFFFFFFFF, 200, 32'h00, 4'h0, 4, 4);
    add(1, 1, 0, 32'hFFFFFFFF, 200, 32'h00, 4'h0, 4, 4);
    add(1, 1, 1, 32'hFFFFFFFF, 200, 32'h00, 4'hF, 0, 0);
    add(1, 1, 1, 32'hFFFFFFFF, 200, 32'h00, 4'h0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].clr, vecs[i].cur, vecs[i].thr);
      check("state", i, st, vecs[i].st);
      check("spike", i, {28'h0, sp}, {28'h0, vecs[i].sp});
      check("count", i, {24'h0, cnt}, {24'h0, vecs[i].cnt});
      check("state_c4", i, st4, vecs[i].st);
      check("spike_c4", i, {28'h0, sp4}, {28'h0, vecs[i].sp});
      check("count_c4", i, {28'h0, cnt4}, {28'h0, vecs[i].cnt4});
    end

    // All channels fire every third step: narrow counter clamps at 15, wide one keeps going
    step(0, 1, 0, 32'hFFFFFFFF, 200);
    check("sat_reset", 0, {24'h0, cnt}, 32'h0);
    for (int s = 1; s <= 15; s++) begin
      step(1, 1, 0, 32'hFFFFFFFF, 200);
      k      = (s - 1) / 3 + 1;
      exp_c4 = (4 * k > 15) ? 15 : 4 * k;
      check("sat_spike", s, {28'h0, sp}, ((s - 1) % 3 == 0) ? 32'hF : 32'h0);
      check("sat_count", s, {24'h0, cnt}, 32'(4 * k));
      check("sat_count_c4", s, {28'h0, cnt4}, 32'(exp_c4));
    end
    step(1, 0, 1, 32'hFFFFFFFF, 200);
    check("sat_clr", 0, {24'h0, cnt}, 32'h0);
    check("sat_clr_c4", 0, {28'h0, cnt4}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of leaky integrate-and-fire neurons, successor to the single-neuron LIF core. Each of `N` channels integrates its own input current with a configurable shift-based leak, fires against a shared runtime threshold, and then observes a refractory period. A step-enable input gates time, and a saturating aggregate spike counter gives the top level a cheap activity readout for `uo_out`/`uio_out` muxing.

## Interface
Parameters:
- `N`, 4: number of neuron channels
- `W`, 8: membrane/current width in bits
- `LEAK_SHIFT`, 1: leak is `state >> LEAK_SHIFT` (1 gives beta = 0.5); legal range 1..W-1
- `REFRAC`, 2: refractory steps after a spike; 0 disables refractoriness
- `CNT_W`, 8: width of aggregate spike counter

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  step enable; one neuron time step per cycle where `en`=1
- `current`  in  N*W  per-channel input current, channel i at `[i*W +: W]`, unsigned
- `threshold`  in  W  shared firing threshold, unsigned; 0 disables firing
- `clr_count`  in  1  synchronous clear of `spike_count`
- `state`  out  N*W  per-channel membrane potential, same packing as `current`
- `spike`  out  N  per-channel spike, one-cycle pulse
- `spike_count`  out  CNT_W  saturating total of spikes across all channels

## Operation
- Per channel: registers `state` (W bits), `spike` (1 bit), refractory counter `r` (width clog2(REFRAC+1), min 1).
- Step (`en`=1), per channel, evaluated on current registered values:
  - If `r` != 0: `state`<=0, `r`<=`r`-1, `spike`<=0; `current` ignored.
  - Else compute `sum = (state >> LEAK_SHIFT) + current` in W+1 bits; saturate to 2^W-1 if it overflows.
  - If `threshold` != 0 and `sum` >= `threshold`: `spike`<=1, `state`<=0, `r`<=REFRAC.
  - Otherwise: `spike`<=0, `state`<=`sum`.
- `en`=0: `state` and `r` hold; `spike`<=0 (pulses never stretch).
- Channels are fully independent; no shared arithmetic across channels except the counter.
- Counter: each cycle, `spike_count` <= sat(`spike_count` + popcount(next `spike` vector)), clamping at 2^CNT_W-1; never wraps.
- `clr_count`=1 wins over simultaneous spikes: `spike_count`<=0 that cycle; those spikes are not counted.
- `threshold` may change any cycle; it takes effect on the next step.

## Timing
- Reset (`rst_n`=0 at edge): `state`=0, `spike`=0, `r`=0, `spike_count`=0 for all channels; reset overrides `en` and `clr_count`. Reset mid-refractory fully clears `r`.
- Latency: `current` sampled at edge k with `en`=1 is reflected in `state`/`spike` immediately after edge k (1 cycle, registered outputs); `spike_count` includes that spike after the same edge k.
- Firing cycle: `state` reads 0 while `spike`=1.
- Refractory: after a spike, the next REFRAC steps (`en`=1 cycles) keep `state`=0 and `spike`=0; cycles with `en`=0 do not decrement `r`.
- Minimum inter-spike interval per channel: REFRAC+1 steps.
- No combinational path from inputs to outputs.

## Test plan
Defaults N=4, W=8, LEAK_SHIFT=1, REFRAC=2, threshold=200 unless stated.
- Periodic firing: ch0 current=120, `en`=1 -> state 120,180,0(spike=1),0,0,120,180,0(spike=1); period 5 steps; `spike_count` increments by 1 per spike.
- Sub-threshold fixed point: ch0 current=100 -> state 100,150,175,187,193,196,198,199,199,... never spikes.
- Saturation/disable: threshold=0, ch1 current=255 -> state 255, then 382 clamps to 255, held; `spike` stays 0.
- Enable gating: ch0 current=120, drop `en` after state=180 for 3 cycles -> state holds 180, `spike`=0; on re-enable next step fires (spike=1, state 0).
- Simultaneous spikes and counter: all channels current=255 -> `spike`=4'b1111 after first step, `spike_count`=4; next step with `clr_count`=1 -> `spike_count`=0; drive to saturation with CNT_W=4 -> holds 15.
- Reset mid-operation: assert `rst_n`=0 for one edge during refractory of ch0 -> all outputs 0, and with current=120 the next step gives state 120 (no residual refractory).
